decode_stage_pipe: RTL
======================

Name: decode_stage_pipe

Overview:
- Parametrised successor to the combinational decode stage: decodes one RISC-V instruction per cycle, reads the integer register file and captures all results in a registered ID/EX pipeline register.
- Adds valid/ready handshakes, load-use hazard detection with bubble insertion, flush, and configurable XLEN/register count.
- Sits between the IF/ID register and the execute stage.

Parameters:
- XLEN, 32, datapath width (32 or 64); immediates are sign-extended to XLEN.
- NUM_REGS, 32, architectural register count (32 = RV32I, 16 = RV32E); localparam AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts it this cycle.
- instruction_in  in  32  raw instruction.
- pc_in  in  XLEN  PC of instruction_in.
- id_flush  in  1  squash the instruction presented this cycle.
- wb_wr_en  in  1  register file write enable.
- wb_wr_addr  in  5  write index.
- wb_wr_data  in  XLEN  write data.
- ex_ready  in  1  execute accepts the ID/EX contents.
- ex_valid  out  1  ID/EX holds a live instruction.
- ex_pc  out  XLEN  registered PC.
- ex_op1, ex_op2  out  XLEN  registered rs1/rs2 values.
- ex_imm  out  XLEN  registered immediate.
- ex_rs1, ex_rs2, ex_rd  out  5  registered register indices.
- ex_opcode  out  7  registered opcode.
- ex_func3  out  3  registered func3.
- ex_func7  out  7  registered func7.
- ex_alu_src  out  1  registered control.
- ex_mem_read, ex_mem_write  out  1  registered control.
- ex_load_type  out  3  registered load code.
- ex_store_type  out  2  registered store code.
- ex_wb_reg_file  out  1  registered control.
- ex_invalid_inst  out  1  registered control.
- load_use_stall  out  1  combinational hazard indication.

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output is 0, ex_load_type=LOAD_DEF, ex_store_type=STORE_DEF, and all registers are 0. Register x0 always reads 0, and writes to it are ignored.
- Register file: synchronous write on clk when wb_wr_en=1 and 0 < wb_wr_addr < NUM_REGS. Reads are combinational. Indices >= NUM_REGS read 0.
- Immediate formats:
  - I: ITYPE, ILOAD, IJALR.
  - S: STYPE.
  - B: BTYPE.
  - J: JTYPE.
  - U: UTYPE, AUIPC.
  - All other opcodes give immediate 0.
- Control decode:
  - alu_src=1 for all opcodes except RTYPE and BTYPE.
  - mem_read=1 for ILOAD; mem_write=1 for STYPE.
  - load_type from func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, other LOAD_DEF. For non-loads, load_type is LOAD_DEF.
  - store_type from func3: 000 SB, 001 SH, 010 SW, other STORE_DEF. For non-stores, store_type is STORE_DEF.
  - wb_reg_file=1 for RTYPE, ITYPE, ILOAD, IJALR, JTYPE, AUIPC and UTYPE, and only when rd != 0.
- invalid_inst=1 when any of the following holds:
  - the opcode is unknown;
  - an RTYPE has func7 other than ADD/SUB codes (exception: 0100000 is also allowed for SRL/SRA);
  - the load or store func3 maps to DEF;
  - any used register index is >= NUM_REGS.
  - When invalid_inst=1, control signals mem_* and wb are forced to 0.
- Advance condition: adv = !ex_valid | ex_ready.
- Load-use hazard: load_use_stall = in_valid & ex_valid & ex_mem_read & ex_rd != 0 & (rs1 == ex_rd | (rs2 == ex_rd & opcode uses rs2)). Opcodes that use rs2 are RTYPE, STYPE and BTYPE.
- in_ready = adv & !load_use_stall.
- Update priority at each clk edge:
  1. reset;
  2. if adv=0, hold all ex_* values;
  3. else if id_flush, !in_valid or load_use_stall, load a bubble (ex_valid=0, controls 0);
  4. else capture the decoded instruction with ex_valid=1.
- Latency: exactly 1 cycle from acceptance to ex_valid.
- A flushed instruction is consumed: in_ready stays asserted, so fetch drops it.
- Same-cycle WB write to a register being read: returns the OLD value unless WB_BYPASS_EN is defined.
- Reset asserted mid-stall clears ex_valid immediately (asynchronously).

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a write-through bypass. If wb_wr_en and wb_wr_addr equals rs1/rs2 (nonzero, < NUM_REGS), op1/op2 take wb_wr_data in the same cycle.
- Undefined: plain register-file read, and the external forwarding unit must cover that case.

Decomposition:
- Shared package/header (the existing defines file):
  - OPCODE_*, FUNC7_*, LOAD_*, STORE_*, ALU_* codes;
  - ZERO constants;
  - a new FUNC7_SRA 7'b0100000 alias.
- One sub-module: decode_ctrl_gen, a combinational opcode/func → control + immediate generator, parametrised by XLEN.
- Register file and pipeline register are inline.

Test Plan:
- Reset then ADDI x5,x0,-1 (0xFFF00293), ex_ready=1 → next cycle:
  - ex_valid=1, ex_imm=0xFFFFFFFF, ex_rd=5;
  - ex_alu_src=1, ex_wb_reg_file=1, ex_invalid_inst=0.
- LW x3,0(x1) accepted, then ADD x4,x3,x2 presented:
  - load_use_stall=1 and in_ready=0 for one cycle;
  - ex_valid=0 (bubble);
  - the ADD is captured the following cycle.
- ex_ready=0 for 3 cycles with ex_valid=1:
  - all ex_* outputs remain stable;
  - in_ready=0;
  - on release, the next instruction is captured once.
- id_flush=1 with a valid SW:
  - in_ready=1, next ex_valid=0;
  - ex_mem_write=0.
- NUM_REGS=16, ADD x20,x1,x2 → ex_invalid_inst=1, ex_wb_reg_file=0.
- WB write x7=0xDEADBEEF in the same cycle as decoding ADD x8,x7,x0:
  - ex_op1=0xDEADBEEF with WB_BYPASS_EN;
  - the old value (0 after reset) without it.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode constants: opcodes, func7 codes, load/store codes, ALU codes and helpers.
// Used by decode_stage_pipe and decode_ctrl_gen.
package decode_stage_pipe_pkg;

   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
   localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
   localparam logic [6:0] OPCODE_ILOAD = 7'b0000011;
   localparam logic [6:0] OPCODE_IJALR = 7'b1100111;
   localparam logic [6:0] OPCODE_STYPE = 7'b0100011;
   localparam logic [6:0] OPCODE_BTYPE = 7'b1100011;
   localparam logic [6:0] OPCODE_JTYPE = 7'b1101111;
   localparam logic [6:0] OPCODE_UTYPE = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;

   localparam logic [6:0] FUNC7_ADD = 7'b0000000;
   localparam logic [6:0] FUNC7_SUB = 7'b0100000;
   localparam logic [6:0] FUNC7_SRA = 7'b0100000;

   localparam logic [2:0] LOAD_LB  = 3'd0;
   localparam logic [2:0] LOAD_LH  = 3'd1;
   localparam logic [2:0] LOAD_LW  = 3'd2;
   localparam logic [2:0] LOAD_LBU = 3'd3;
   localparam logic [2:0] LOAD_LHU = 3'd4;
   localparam logic [2:0] LOAD_DEF = 3'd7;

   localparam logic [1:0] STORE_SB  = 2'd0;
   localparam logic [1:0] STORE_SH  = 2'd1;
   localparam logic [1:0] STORE_SW  = 2'd2;
   localparam logic [1:0] STORE_DEF = 2'd3;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;

   localparam logic [4:0] ZERO_REG = 5'd0;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_J,
      IMM_U
   } imm_fmt_e;

   function automatic logic uses_rs2(input logic [6:0] opc);
      return (opc == OPCODE_RTYPE) || (opc == OPCODE_STYPE) || (opc == OPCODE_BTYPE);
   endfunction

endpackage

// File: rtl/decode_stage_pipe_ctrl_gen.sv
// decode_ctrl_gen: combinational opcode/func decode into controls and a sign-extended immediate.
// Register-range checks are left to the caller, which knows the register count.
module decode_ctrl_gen
   import decode_stage_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o,
   output logic            alu_src_o,
   output logic            mem_read_o,
   output logic            mem_write_o,
   output logic [2:0]      load_type_o,
   output logic [1:0]      store_type_o,
   output logic            wb_reg_file_o,
   output logic            invalid_o,
   output logic            use_rs1_o,
   output logic            use_rs2_o,
   output logic            use_rd_o
);

   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [4:0]  rd;
   imm_fmt_e    imm_fmt;
   logic [31:0] imm32;
   logic        bad_enc;
   logic        wb_cand;
   logic        is_load;
   logic        is_store;

   assign opcode = instr_i[6:0];
   assign func3  = instr_i[14:12];
   assign func7  = instr_i[31:25];
   assign rd     = instr_i[11:7];

   always_comb begin
      imm_fmt     = IMM_NONE;
      bad_enc     = 1'b0;
      wb_cand     = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      use_rs1_o   = 1'b0;
      use_rd_o    = 1'b0;
      load_type_o  = LOAD_DEF;
      store_type_o = STORE_DEF;
      case (opcode)
         OPCODE_RTYPE: begin
            use_rs1_o = 1'b1;
            use_rd_o  = 1'b1;
            wb_cand   = 1'b1;
            // 0100000 covers both SUB and SRA
            if (func7 != FUNC7_ADD && func7 != FUNC7_SUB) bad_enc = 1'b1;
         end
         OPCODE_ITYPE, OPCODE_IJALR: begin
            imm_fmt   = IMM_I;
            use_rs1_o = 1'b1;
            use_rd_o  = 1'b1;
            wb_cand   = 1'b1;
         end
         OPCODE_ILOAD: begin
            imm_fmt   = IMM_I;
            use_rs1_o = 1'b1;
            use_rd_o  = 1'b1;
            wb_cand   = 1'b1;
            is_load   = 1'b1;
            case (func3)
               3'b000:  load_type_o = LOAD_LB;
               3'b001:  load_type_o = LOAD_LH;
               3'b010:  load_type_o = LOAD_LW;
               3'b100:  load_type_o = LOAD_LBU;
               3'b101:  load_type_o = LOAD_LHU;
               default: load_type_o = LOAD_DEF;
            endcase
            if (load_type_o == LOAD_DEF) bad_enc = 1'b1;
         end
         OPCODE_STYPE: begin
            imm_fmt   = IMM_S;
            use_rs1_o = 1'b1;
            is_store  = 1'b1;
            case (func3)
               3'b000:  store_type_o = STORE_SB;
               3'b001:  store_type_o = STORE_SH;
               3'b010:  store_type_o = STORE_SW;
               default: store_type_o = STORE_DEF;
            endcase
            if (store_type_o == STORE_DEF) bad_enc = 1'b1;
         end
         OPCODE_BTYPE: begin
            imm_fmt   = IMM_B;
            use_rs1_o = 1'b1;
         end
         OPCODE_JTYPE: begin
            imm_fmt  = IMM_J;
            use_rd_o = 1'b1;
            wb_cand  = 1'b1;
         end
         OPCODE_UTYPE, OPCODE_AUIPC: begin
            imm_fmt  = IMM_U;
            use_rd_o = 1'b1;
            wb_cand  = 1'b1;
         end
         default: bad_enc = 1'b1;
      endcase
   end

   always_comb begin
      case (imm_fmt)
         IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
         IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
         IMM_U:   imm32 = {instr_i[31:12], 12'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm_o         = XLEN'($signed(imm32));
   assign use_rs2_o     = uses_rs2(opcode);
   assign alu_src_o     = !(opcode == OPCODE_RTYPE || opcode == OPCODE_BTYPE);
   assign mem_read_o    = is_load & ~bad_enc;
   assign mem_write_o   = is_store & ~bad_enc;
   assign wb_reg_file_o = wb_cand & (rd != ZERO_REG) & ~bad_enc;
   assign invalid_o     = bad_enc;

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: register-file read, load-use hazard bubble and registered ID/EX stage.
// Optional WB_BYPASS_EN macro adds a same-cycle write-through from the WB port to the operands.
module decode_stage_pipe
   import decode_stage_pipe_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic            id_flush,
   input  logic            wb_wr_en,
   input  logic [4:0]      wb_wr_addr,
   input  logic [XLEN-1:0] wb_wr_data,
   input  logic            ex_ready,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_op1,
   output logic [XLEN-1:0] ex_op2,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_func3,
   output logic [6:0]      ex_func7,
   output logic            ex_alu_src,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic [2:0]      ex_load_type,
   output logic [1:0]      ex_store_type,
   output logic            ex_wb_reg_file,
   output logic            ex_invalid_inst,
   output logic            load_use_stall
);

   localparam int         AW    = $clog2(NUM_REGS);
   localparam logic [5:0] NREGS = 6'(NUM_REGS);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      func3;
      logic [6:0]      func7;
      logic            alu_src;
      logic            mem_read;
      logic            mem_write;
      logic [2:0]      load_type;
      logic [1:0]      store_type;
      logic            wb_reg_file;
      logic            invalid_inst;
   } ex_t;

   function automatic logic idx_ok(input logic [4:0] idx);
      return {1'b0, idx} < NREGS;
   endfunction

   logic [XLEN-1:0] rf_q [NUM_REGS];
   logic [XLEN-1:0] rf_d [NUM_REGS];
   ex_t             ex_q;
   ex_t             ex_d;

   logic [6:0]      opcode;
   logic [4:0]      rs1_idx;
   logic [4:0]      rs2_idx;
   logic [4:0]      rd_idx;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] ctrl_imm;
   logic            ctrl_alu_src;
   logic            ctrl_mem_read;
   logic            ctrl_mem_write;
   logic [2:0]      ctrl_load_type;
   logic [1:0]      ctrl_store_type;
   logic            ctrl_wb;
   logic            ctrl_invalid;
   logic            use_rs1;
   logic            use_rs2;
   logic            use_rd;
   logic            range_bad;
   logic            adv;

   assign opcode  = instruction_in[6:0];
   assign rs1_idx = instruction_in[19:15];
   assign rs2_idx = instruction_in[24:20];
   assign rd_idx  = instruction_in[11:7];

   decode_ctrl_gen #(.XLEN(XLEN)) u_ctrl_gen (
      .instr_i       (instruction_in),
      .imm_o         (ctrl_imm),
      .alu_src_o     (ctrl_alu_src),
      .mem_read_o    (ctrl_mem_read),
      .mem_write_o   (ctrl_mem_write),
      .load_type_o   (ctrl_load_type),
      .store_type_o  (ctrl_store_type),
      .wb_reg_file_o (ctrl_wb),
      .invalid_o     (ctrl_invalid),
      .use_rs1_o     (use_rs1),
      .use_rs2_o     (use_rs2),
      .use_rd_o      (use_rd)
   );

   always_comb begin
      rf_d = rf_q;
      if (wb_wr_en && wb_wr_addr != ZERO_REG && idx_ok(wb_wr_addr))
         rf_d[wb_wr_addr[AW-1:0]] = wb_wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rf_q <= '{default: '0};
      else      rf_q <= rf_d;
   end

   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1_idx != ZERO_REG && idx_ok(rs1_idx)) rs1_val = rf_q[rs1_idx[AW-1:0]];
      if (rs2_idx != ZERO_REG && idx_ok(rs2_idx)) rs2_val = rf_q[rs2_idx[AW-1:0]];
`ifdef WB_BYPASS_EN
      if (wb_wr_en && wb_wr_addr == rs1_idx && rs1_idx != ZERO_REG && idx_ok(rs1_idx))
         rs1_val = wb_wr_data;
      if (wb_wr_en && wb_wr_addr == rs2_idx && rs2_idx != ZERO_REG && idx_ok(rs2_idx))
         rs2_val = wb_wr_data;
`endif
   end

   assign range_bad = (use_rs1 & ~idx_ok(rs1_idx)) | (use_rs2 & ~idx_ok(rs2_idx))
                    | (use_rd & ~idx_ok(rd_idx));

   // rs1 is compared for every opcode; only rs2 is qualified by use
   assign load_use_stall = in_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != ZERO_REG)
                         & ((rs1_idx == ex_q.rd) | ((rs2_idx == ex_q.rd) & uses_rs2(opcode)));
   assign adv      = ~ex_q.valid | ex_ready;
   assign in_ready = adv & ~load_use_stall;

   always_comb begin
      ex_d = ex_q;
      if (adv) begin
         if (id_flush || !in_valid || load_use_stall) begin
            ex_d            = '0;
            ex_d.load_type  = LOAD_DEF;
            ex_d.store_type = STORE_DEF;
         end else begin
            ex_d.valid        = 1'b1;
            ex_d.pc           = pc_in;
            ex_d.op1          = rs1_val;
            ex_d.op2          = rs2_val;
            ex_d.imm          = ctrl_imm;
            ex_d.rs1          = rs1_idx;
            ex_d.rs2          = rs2_idx;
            ex_d.rd           = rd_idx;
            ex_d.opcode       = opcode;
            ex_d.func3        = instruction_in[14:12];
            ex_d.func7        = instruction_in[31:25];
            ex_d.alu_src      = ctrl_alu_src;
            ex_d.mem_read     = ctrl_mem_read & ~range_bad;
            ex_d.mem_write    = ctrl_mem_write & ~range_bad;
            ex_d.load_type    = ctrl_load_type;
            ex_d.store_type   = ctrl_store_type;
            ex_d.wb_reg_file  = ctrl_wb & ~range_bad;
            ex_d.invalid_inst = ctrl_invalid | range_bad;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q            <= '0;
         ex_q.load_type  <= LOAD_DEF;
         ex_q.store_type <= STORE_DEF;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign ex_valid        = ex_q.valid;
   assign ex_pc           = ex_q.pc;
   assign ex_op1          = ex_q.op1;
   assign ex_op2          = ex_q.op2;
   assign ex_imm          = ex_q.imm;
   assign ex_rs1          = ex_q.rs1;
   assign ex_rs2          = ex_q.rs2;
   assign ex_rd           = ex_q.rd;
   assign ex_opcode       = ex_q.opcode;
   assign ex_func3        = ex_q.func3;
   assign ex_func7        = ex_q.func7;
   assign ex_alu_src      = ex_q.alu_src;
   assign ex_mem_read     = ex_q.mem_read;
   assign ex_mem_write    = ex_q.mem_write;
   assign ex_load_type    = ex_q.load_type;
   assign ex_store_type   = ex_q.store_type;
   assign ex_wb_reg_file  = ex_q.wb_reg_file;
   assign ex_invalid_inst = ex_q.invalid_inst;

endmodule
